com_sender_param: RTL and testbench
===================================

Name: com_sender_param

Overview:
- Parametrised successor to the two-byte command sender.
- Sends a CMD_BYTES-wide command MSB-byte-first over a byte-wide UART transmit handshake.
- Then collects a RESP_BYTES-wide response from the UART receive handshake, with a response timeout.
- Sits between the host command logic and the team's UART transceiver, which is instantiated outside this block and wired to the trmt/tx_*/rx_* ports.

Parameters:
CMD_BYTES, 2, command length in bytes (>=1)
RESP_BYTES, 1, response length in bytes (>=1)
TIMEOUT_CYC, 1000000, clocks to wait for each response byte; 0 disables timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd  input  8*CMD_BYTES  command word, MSB byte sent first
send_cmd  input  1  start request, single-cycle pulse
busy  output  1  high outside IDLE
cmd_sent  output  1  all command bytes transmitted
resp  output  8*RESP_BYTES  assembled response, first received byte in MSB
resp_rdy  output  1  full response available
clr_resp_rdy  input  1  host acknowledge for resp_rdy
timeout  output  1  response not completed in time
trmt  output  1  one-cycle transmit strobe to UART
tx_data  output  8  byte to transmit, valid while trmt high
tx_done  input  1  UART finished current byte
rx_rdy  input  1  UART holds a received byte
rx_data  input  8  received byte
clr_rx_rdy  output  1  consume received byte

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy, cmd_sent, resp_rdy, timeout, trmt all 0; resp 0; tx_data 0; state IDLE.
- Registered outputs: trmt and tx_data are registered. clr_rx_rdy is combinational and equals rx_rdy in every state, so each received byte is consumed the cycle it is presented.
- States: IDLE, TX, WAIT_RESP.
- IDLE:
  - send_cmd at edge N latches cmd into a shift register and clears cmd_sent, resp_rdy and timeout.
  - Byte counter loads 0; next state is TX.
  - At the same edge, trmt<=1 and tx_data<=cmd[8*CMD_BYTES-1 -: 8]. trmt is therefore high during cycle N+1 only.
- TX:
  - On tx_done, if the counter is below CMD_BYTES-1: increment the counter, shift left 8, pulse trmt with the next byte at the same edge.
  - On tx_done for the last byte: set cmd_sent, clear the timeout counter, go to WAIT_RESP.
  - tx_done in IDLE or WAIT_RESP is ignored.
- WAIT_RESP:
  - On rx_rdy: shift rx_data into resp from the LSB side, so after RESP_BYTES bytes the first byte sits in the MSB. Clear the timeout counter and count the byte.
  - The final byte sets resp_rdy and returns to IDLE.
  - Without rx_rdy, the timeout counter increments. When it equals TIMEOUT_CYC-1 with no rx_rdy that cycle: set timeout, leave resp_rdy 0, return to IDLE.
  - resp is updated only through the shift path; a timed-out partial response leaves resp holding the partially shifted value.
  - Timeout therefore rises exactly TIMEOUT_CYC cycles after cmd_sent rises, or after the last received byte.
  - TIMEOUT_CYC=0: never time out.
- Received bytes outside WAIT_RESP are discarded: clr_rx_rdy still pulses and resp is unchanged.
- send_cmd while busy is ignored: no state, cmd_sent or resp change.
- resp_rdy:
  - Cleared by clr_resp_rdy or by an accepted send_cmd.
  - Set wins over clr_resp_rdy in the same cycle.
- Holding values: resp holds until the next completed response. cmd_sent holds until the next accepted send_cmd.
- Timeout counter width is $clog2(TIMEOUT_CYC+1), minimum 1.
- Reset mid-operation: immediate return to reset values. No further trmt is issued until a new send_cmd.

Test Plan:
- Defaults, cmd=16'hA55A, send_cmd at N -> trmt@N+1 tx_data=A5; tx_done -> trmt next cycle tx_data=5A; second tx_done -> cmd_sent=1, busy stays 1 in WAIT_RESP; rx byte 3C -> resp=8'h3C, resp_rdy=1, busy=0.
- CMD_BYTES=3, RESP_BYTES=2, cmd=24'h123456 -> three trmt pulses with 12, 34, 56; rx AB then CD -> resp=16'hABCD, resp_rdy=1, clr_rx_rdy pulsed twice.
- TIMEOUT_CYC=100, no rx after cmd_sent -> timeout=1 exactly 100 cycles after cmd_sent rises, resp_rdy=0, busy=0; next send_cmd clears timeout.
- send_cmd pulsed mid-TX with a different cmd -> ignored, original bytes sent. Rx byte 77 while IDLE -> clr_rx_rdy=1, resp unchanged.
- rst_n low between the first and second tx_done -> all outputs 0 asynchronously; second tx_done then gives no trmt and cmd_sent stays 0.
- clr_resp_rdy high in the same cycle the final response byte arrives -> resp_rdy=1; clr_resp_rdy next cycle -> resp_rdy=0.

Source files
------------

// File: rtl/com_sender_param.sv
// Command sender: shifts a multi-byte command out over the UART
// transmit handshake, then gathers a multi-byte response with timeout.
module com_sender_param #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*CMD_BYTES-1:0]  cmd,
  input  logic                    send_cmd,
  output logic                    busy,
  output logic                    cmd_sent,
  output logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_rdy,
  input  logic                    clr_resp_rdy,
  output logic                    timeout,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy
);

  localparam int CW = 8 * CMD_BYTES;
  localparam int RW = 8 * RESP_BYTES;
  localparam int NB = (CMD_BYTES > RESP_BYTES) ? CMD_BYTES : RESP_BYTES;
  localparam int NW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TL = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  localparam logic [NW-1:0] CLAST = NW'(CMD_BYTES - 1);
  localparam logic [NW-1:0] RLAST = NW'(RESP_BYTES - 1);
  localparam logic [TW-1:0] TLIM  = TW'(TL);

  typedef enum logic [1:0] {
    IDLE,
    TX,
    WAIT_RESP
  } state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_sh, w_sh_n, w_shl;
  logic [NW-1:0] r_cnt, w_cnt_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n;
  logic [RW-1:0] r_resp, w_resp_n, w_rshl;
  logic          r_cmd_sent, w_sent_n;
  logic          r_resp_rdy, w_rdy_n;
  logic          r_timeout, w_to_n;
  logic          r_trmt, w_trmt_n;
  logic [7:0]    r_tx_data, w_txd_n;

  assign w_shl  = r_sh << 8;
  assign w_rshl = (r_resp << 8) | RW'(rx_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_tcnt     <= '0;
      r_resp     <= '0;
      r_cmd_sent <= 1'b0;
      r_resp_rdy <= 1'b0;
      r_timeout  <= 1'b0;
      r_trmt     <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_sh       <= w_sh_n;
      r_cnt      <= w_cnt_n;
      r_tcnt     <= w_tcnt_n;
      r_resp     <= w_resp_n;
      r_cmd_sent <= w_sent_n;
      r_resp_rdy <= w_rdy_n;
      r_timeout  <= w_to_n;
      r_trmt     <= w_trmt_n;
      r_tx_data  <= w_txd_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_cnt_n   = r_cnt;
    w_tcnt_n  = r_tcnt;
    w_resp_n  = r_resp;
    w_sent_n  = r_cmd_sent;
    w_rdy_n   = r_resp_rdy;
    w_to_n    = r_timeout;
    w_trmt_n  = 1'b0;
    w_txd_n   = r_tx_data;
    // A set of resp_rdy below overrides this clear
    if (clr_resp_rdy) w_rdy_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (send_cmd) begin
          w_sh_n    = cmd;
          w_cnt_n   = '0;
          w_sent_n  = 1'b0;
          w_rdy_n   = 1'b0;
          w_to_n    = 1'b0;
          w_trmt_n  = 1'b1;
          w_txd_n   = cmd[CW-1 -: 8];
          w_state_n = TX;
        end
      end
      TX: begin
        if (tx_done) begin
          if (r_cnt == CLAST) begin
            w_sent_n  = 1'b1;
            w_tcnt_n  = '0;
            w_cnt_n   = '0;
            w_state_n = WAIT_RESP;
          end else begin
            w_cnt_n  = r_cnt + 1'b1;
            w_sh_n   = w_shl;
            w_trmt_n = 1'b1;
            w_txd_n  = w_shl[CW-1 -: 8];
          end
        end
      end
      WAIT_RESP: begin
        if (rx_rdy) begin
          w_resp_n = w_rshl;
          w_tcnt_n = '0;
          if (r_cnt == RLAST) begin
            w_rdy_n   = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end else if (TIMEOUT_CYC != 0 && r_tcnt == TLIM) begin
          w_to_n    = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_tcnt_n = r_tcnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign cmd_sent   = r_cmd_sent;
  assign resp       = r_resp;
  assign resp_rdy   = r_resp_rdy;
  assign timeout    = r_timeout;
  assign trmt       = r_trmt;
  assign tx_data    = r_tx_data;
  assign clr_rx_rdy = rx_rdy;

endmodule

// File: tb/tb_com_sender_param.sv
// Directed bench for com_sender_param: default build plus a
// 3-byte command / 2-byte response build with a short timeout.
module tb_com_sender_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Instance A: defaults
  logic [15:0] a_cmd;
  logic        a_send, a_busy, a_sent, a_rdy, a_clr_rdy, a_to;
  logic [7:0]  a_resp;
  logic        a_trmt, a_txd_done, a_rx_rdy, a_clr_rx;
  logic [7:0]  a_txd, a_rxd;

  com_sender_param u_a (
    .clk(clk), .rst_n(rst_n), .cmd(a_cmd), .send_cmd(a_send),
    .busy(a_busy), .cmd_sent(a_sent), .resp(a_resp),
    .resp_rdy(a_rdy), .clr_resp_rdy(a_clr_rdy), .timeout(a_to),
    .trmt(a_trmt), .tx_data(a_txd), .tx_done(a_txd_done),
    .rx_rdy(a_rx_rdy), .rx_data(a_rxd), .clr_rx_rdy(a_clr_rx)
  );

  // Instance B: 3-byte command, 2-byte response, 100-cycle timeout
  logic [23:0] b_cmd;
  logic        b_send, b_busy, b_sent, b_rdy, b_clr_rdy, b_to;
  logic [15:0] b_resp;
  logic        b_trmt, b_txd_done, b_rx_rdy, b_clr_rx;
  logic [7:0]  b_txd, b_rxd;

  com_sender_param #(
    .CMD_BYTES(3), .RESP_BYTES(2), .TIMEOUT_CYC(100)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .cmd(b_cmd), .send_cmd(b_send),
    .busy(b_busy), .cmd_sent(b_sent), .resp(b_resp),
    .resp_rdy(b_rdy), .clr_resp_rdy(b_clr_rdy), .timeout(b_to),
    .trmt(b_trmt), .tx_data(b_txd), .tx_done(b_txd_done),
    .rx_rdy(b_rx_rdy), .rx_data(b_rxd), .clr_rx_rdy(b_clr_rx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Send a command on B through all three bytes; cmd_sent rises at last edge
  task automatic b_send_all(input logic [23:0] c);
    b_cmd = c; b_send = 1'b1;
    tick();
    b_send = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_txd_done = 1'b1;
      tick();
      b_txd_done = 1'b0;
    end
    chk("b_sent_all", {31'd0, b_sent}, 32'd1);
  endtask

  logic [7:0] b_exp [2];

  initial begin
    b_exp[0] = 8'h34;
    b_exp[1] = 8'h56;
    rst_n = 1'b0;
    a_cmd = '0; a_send = 0; a_clr_rdy = 0; a_txd_done = 0;
    a_rx_rdy = 0; a_rxd = '0;
    b_cmd = '0; b_send = 0; b_clr_rdy = 0; b_txd_done = 0;
    b_rx_rdy = 0; b_rxd = '0;
    repeat (2) tick();
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_sent", {31'd0, a_sent}, 32'd0);
    chk("rst_rdy", {31'd0, a_rdy}, 32'd0);
    chk("rst_to", {31'd0, a_to}, 32'd0);
    chk("rst_trmt", {31'd0, a_trmt}, 32'd0);
    chk("rst_resp", {24'd0, a_resp}, 32'd0);
    chk("rst_txd", {24'd0, a_txd}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Default build: A55A out, 3C back, with a stray send mid-TX
    a_cmd = 16'hA55A; a_send = 1'b1;
    tick();
    a_send = 1'b0;
    chk("a_trmt1", {31'd0, a_trmt}, 32'd1);
    chk("a_txd1", {24'd0, a_txd}, 32'h A5);
    chk("a_busy1", {31'd0, a_busy}, 32'd1);
    tick();
    chk("a_trmt_pulse", {31'd0, a_trmt}, 32'd0);
    a_cmd = 16'hFFFF; a_send = 1'b1;
    tick();
    a_send = 1'b0;
    chk("a_ign_trmt", {31'd0, a_trmt}, 32'd0);
    chk("a_ign_busy", {31'd0, a_busy}, 32'd1);
    a_txd_done = 1'b1;
    tick();
    a_txd_done = 1'b0;
    chk("a_trmt2", {31'd0, a_trmt}, 32'd1);
    chk("a_txd2", {24'd0, a_txd}, 32'h5A);
    chk("a_sent_early", {31'd0, a_sent}, 32'd0);
    tick();
    a_txd_done = 1'b1;
    tick();
    a_txd_done = 1'b0;
    chk("a_sent", {31'd0, a_sent}, 32'd1);
    chk("a_busy_wr", {31'd0, a_busy}, 32'd1);
    chk("a_trmt_none", {31'd0, a_trmt}, 32'd0);
    a_rxd = 8'h3C; a_rx_rdy = 1'b1; a_clr_rdy = 1'b1;
    #1;
    chk("a_clr_rx", {31'd0, a_clr_rx}, 32'd1);
    tick();
    a_rx_rdy = 1'b0; a_clr_rdy = 1'b0;
    chk("a_resp", {24'd0, a_resp}, 32'h3C);
    chk("a_rdy_setwins", {31'd0, a_rdy}, 32'd1);
    chk("a_busy_done", {31'd0, a_busy}, 32'd0);
    a_clr_rdy = 1'b1;
    tick();
    a_clr_rdy = 1'b0;
    chk("a_rdy_clr", {31'd0, a_rdy}, 32'd0);
    chk("a_sent_hold", {31'd0, a_sent}, 32'd1);

    // Byte arriving in IDLE is consumed but discarded
    a_rxd = 8'h77; a_rx_rdy = 1'b1;
    #1;
    chk("a_idle_clr_rx", {31'd0, a_clr_rx}, 32'd1);
    tick();
    a_rx_rdy = 1'b0;
    chk("a_idle_resp", {24'd0, a_resp}, 32'h3C);
    chk("a_idle_busy", {31'd0, a_busy}, 32'd0);

    // Instance B: three bytes out, AB CD back
    b_cmd = 24'h123456; b_send = 1'b1;
    tick();
    b_send = 1'b0;
    chk("b_trmt0", {31'd0, b_trmt}, 32'd1);
    chk("b_txd0", {24'd0, b_txd}, 32'h12);
    for (int i = 0; i < 2; i++) begin
      b_txd_done = 1'b1;
      tick();
      b_txd_done = 1'b0;
      chk("b_trmtn", {31'd0, b_trmt}, 32'd1);
      chk("b_txdn", {24'd0, b_txd}, {24'd0, b_exp[i]});
    end
    b_txd_done = 1'b1;
    tick();
    b_txd_done = 1'b0;
    chk("b_sent", {31'd0, b_sent}, 32'd1);
    b_rxd = 8'hAB; b_rx_rdy = 1'b1;
    #1;
    chk("b_clr_rx1", {31'd0, b_clr_rx}, 32'd1);
    tick();
    b_rx_rdy = 1'b0;
    chk("b_rdy_part", {31'd0, b_rdy}, 32'd0);
    chk("b_busy_part", {31'd0, b_busy}, 32'd1);
    repeat (3) tick();
    b_rxd = 8'hCD; b_rx_rdy = 1'b1;
    #1;
    chk("b_clr_rx2", {31'd0, b_clr_rx}, 32'd1);
    tick();
    b_rx_rdy = 1'b0;
    chk("b_resp", {16'd0, b_resp}, 32'hABCD);
    chk("b_rdy", {31'd0, b_rdy}, 32'd1);
    chk("b_busy_done", {31'd0, b_busy}, 32'd0);

    // Timeout with no response: 100 cycles after cmd_sent rises
    b_send_all(24'h010203);
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99) chk("b_to_early", {31'd0, b_to}, 32'd0);
    end
    chk("b_to", {31'd0, b_to}, 32'd1);
    chk("b_to_rdy", {31'd0, b_rdy}, 32'd0);
    chk("b_to_busy", {31'd0, b_busy}, 32'd0);
    chk("b_to_resp", {16'd0, b_resp}, 32'hABCD);
    b_cmd = 24'h0; b_send = 1'b1;
    tick();
    b_send = 1'b0;
    chk("b_to_clr", {31'd0, b_to}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      b_txd_done = 1'b1;
      tick();
      b_txd_done = 1'b0;
    end
    chk("b_sent2", {31'd0, b_sent}, 32'd1);

    // Partial response then timeout: counted from the last byte
    repeat (10) tick();
    b_rxd = 8'hEE; b_rx_rdy = 1'b1;
    tick();
    b_rx_rdy = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99) chk("b_pto_early", {31'd0, b_to}, 32'd0);
    end
    chk("b_pto", {31'd0, b_to}, 32'd1);
    chk("b_pto_resp", {16'd0, b_resp}, 32'hCDEE);
    chk("b_pto_rdy", {31'd0, b_rdy}, 32'd0);

    // Reset between the first and second tx_done on A
    a_cmd = 16'hA55A; a_send = 1'b1;
    tick();
    a_send = 1'b0;
    a_txd_done = 1'b1;
    tick();
    a_txd_done = 1'b0;
    chk("a_r_trmt", {31'd0, a_trmt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_r_busy", {31'd0, a_busy}, 32'd0);
    chk("a_r_trmt0", {31'd0, a_trmt}, 32'd0);
    chk("a_r_txd", {24'd0, a_txd}, 32'd0);
    chk("a_r_resp", {24'd0, a_resp}, 32'd0);
    tick();
    rst_n = 1'b1;
    a_txd_done = 1'b1;
    tick();
    a_txd_done = 1'b0;
    chk("a_r_notrmt", {31'd0, a_trmt}, 32'd0);
    chk("a_r_sent", {31'd0, a_sent}, 32'd0);
    chk("a_r_idle", {31'd0, a_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
